// File: rtl/csr_pkg.sv
// Shared CSR bus types: the request/response pair between master and targets,
// and the local access strobe a target presents to its owning register file.
package csr_pkg;

   localparam int CSR_SELECT_WIDTH  = 16;
   localparam int CSR_ADDRESS_WIDTH = 16;
   localparam int CSR_DATA_WIDTH    = 32;

   typedef struct packed {
      logic                         valid;
      logic                         read_not_write;
      logic [CSR_SELECT_WIDTH-1:0]  select;
      logic [CSR_ADDRESS_WIDTH-1:0] address;
      logic [CSR_DATA_WIDTH-1:0]    data;
   } t_csr_request;

   typedef struct packed {
      logic                      acknowledge;
      logic                      read_data_valid;
      logic                      read_data_error;
      logic [CSR_DATA_WIDTH-1:0] read_data;
   } t_csr_response;

   typedef struct packed {
      logic                         valid;
      logic                         read_not_write;
      logic [CSR_ADDRESS_WIDTH-1:0] address;
      logic [CSR_DATA_WIDTH-1:0]    data;
   } t_csr_access;

endpackage

// File: rtl/csr_target_access.sv
// CSR target responder: accepts one request for its select id, acknowledges it,
// runs a single local access with optional timeout, and returns read data for
// one cycle. Response outputs are zero whenever idle so targets can be OR-ed.
module csr_target_access
   import csr_pkg::*;
#(
   parameter int ACCESS_TIMEOUT = 255
) (
   input  logic                         clk,
   input  logic                         clk__enable,
   input  logic                         reset_n,
   input  logic [CSR_SELECT_WIDTH-1:0]  csr_select,
   input  logic                         csr_request__valid,
   input  logic                         csr_request__read_not_write,
   input  logic [CSR_SELECT_WIDTH-1:0]  csr_request__select,
   input  logic [CSR_ADDRESS_WIDTH-1:0] csr_request__address,
   input  logic [CSR_DATA_WIDTH-1:0]    csr_request__data,
   output logic                         csr_response__acknowledge,
   output logic                         csr_response__read_data_valid,
   output logic                         csr_response__read_data_error,
   output logic [CSR_DATA_WIDTH-1:0]    csr_response__read_data,
   output logic                         csr_access__valid,
   output logic                         csr_access__read_not_write,
   output logic [CSR_ADDRESS_WIDTH-1:0] csr_access__address,
   output logic [CSR_DATA_WIDTH-1:0]    csr_access__data,
   input  logic                         csr_access_ack,
   input  logic                         csr_access_error,
   input  logic [CSR_DATA_WIDTH-1:0]    csr_read_data
);

   typedef enum logic [1:0] {IDLE, ACKED, ACCESS, RESPOND} t_csr_target_state;

   localparam int               CNT_W      = (ACCESS_TIMEOUT < 1) ? 1 : $clog2(ACCESS_TIMEOUT + 1);
   localparam bit               TIMEOUT_EN = (ACCESS_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST   = TIMEOUT_EN ? CNT_W'(ACCESS_TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   t_csr_target_state state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   t_csr_access       access_q, access_d;
   t_csr_response     resp_q, resp_d;
   t_csr_request      req;
   logic              req_match;

   // Gather the flat request ports into one struct for decoding.
   always_comb begin
      req.valid          = csr_request__valid;
      req.read_not_write = csr_request__read_not_write;
      req.select         = csr_request__select;
      req.address        = csr_request__address;
      req.data           = csr_request__data;
   end

   assign req_match = req.valid && (req.select == csr_select);

   // Next-state logic; response fields default to zero so they only pulse when set.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      access_d = access_q;
      resp_d   = '0;
      case (state_q)
         IDLE: begin
            if (req_match) begin
               access_d.read_not_write = req.read_not_write;
               access_d.address        = req.address;
               access_d.data           = req.data;
               resp_d.acknowledge      = 1'b1;
               state_d                 = ACKED;
            end
         end
         ACKED: begin
            if (req.valid) begin
               resp_d.acknowledge = 1'b1;
            end else begin
               access_d.valid = 1'b1;
               cnt_d          = '0;
               state_d        = ACCESS;
            end
         end
         ACCESS: begin
            if (csr_access_ack) begin
               cnt_d          = '0;
               access_d.valid = 1'b0;
               if (access_q.read_not_write) begin
                  resp_d.read_data_valid = 1'b1;
                  resp_d.read_data_error = csr_access_error;
                  resp_d.read_data       = csr_read_data;
                  state_d                = RESPOND;
               end else begin
                  state_d = IDLE;
               end
            end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
               cnt_d          = '0;
               access_d.valid = 1'b0;
               if (access_q.read_not_write) begin
                  resp_d.read_data_valid = 1'b1;
                  resp_d.read_data_error = 1'b1;
                  state_d                = RESPOND;
               end else begin
                  state_d = IDLE;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; frozen while the clock enable is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         access_q <= '0;
         resp_q   <= '0;
      end else if (clk__enable) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         access_q <= access_d;
         resp_q   <= resp_d;
      end
   end

   assign csr_response__acknowledge     = resp_q.acknowledge;
   assign csr_response__read_data_valid = resp_q.read_data_valid;
   assign csr_response__read_data_error = resp_q.read_data_error;
   assign csr_response__read_data       = resp_q.read_data;
   assign csr_access__valid             = access_q.valid;
   assign csr_access__read_not_write    = access_q.read_not_write;
   assign csr_access__address           = access_q.address;
   assign csr_access__data              = access_q.data;

endmodule
